// File: rtl/sequence_checker.sv
// sequence_checker: checks a (value, done) stream against start/step/range; SEQ_CHECKER_LEARN_EN learns start and step from the stream
module sequence_checker #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] start_value,
    input  logic signed [DATA_W-1:0] step,
    input  logic signed [DATA_W-1:0] range_min,
    input  logic signed [DATA_W-1:0] range_max,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_value,
    input  logic                     in_done,
    output logic                     active,
    output logic                     mismatch,
    output logic signed [DATA_W-1:0] mismatch_expected,
    output logic [CNT_W-1:0]         match_count,
    output logic [CNT_W-1:0]         error_count,
    output logic                     done_error,
    output logic                     complete,
    output logic                     pass
);
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;
    state_t r_state, w_state_nxt;
    logic signed [DATA_W-1:0] r_step, r_min, r_max, r_exp;
    logic signed [DATA_W-1:0] w_base, w_step_cur;
    logic signed [DATA_W:0]   w_next, w_min_x, w_max_x;
    logic w_sample, w_start_oob, w_match, w_end, w_term, w_derr;
`ifdef SEQ_CHECKER_LEARN_EN
    logic [1:0] r_phase;
    logic       w_oob0;
`endif

    // sample qualification, expected-value arithmetic and end detection at DATA_W+1 bits
    always_comb begin
        w_sample = enable && (r_state == S_CHECK) && in_valid;
        w_min_x  = {r_min[DATA_W-1], r_min};
        w_max_x  = {r_max[DATA_W-1], r_max};
`ifdef SEQ_CHECKER_LEARN_EN
        w_start_oob = 1'b0;
        w_base      = (r_phase == 2'd2) ? r_exp : in_value;
        w_step_cur  = (r_phase == 2'd1) ? in_value - r_exp : r_step;
        w_match     = (r_phase == 2'd2) ? (in_value == r_exp) : 1'b1;
        w_oob0      = (in_value < r_min) || (in_value > r_max);
`else
        w_start_oob = (start_value < range_min) || (start_value > range_max);
        w_base      = r_exp;
        w_step_cur  = r_step;
        w_match     = (in_value == r_exp);
`endif
        w_next = {w_base[DATA_W-1], w_base} + {w_step_cur[DATA_W-1], w_step_cur};
        w_end  = (w_next < w_min_x) || (w_next > w_max_x);
`ifdef SEQ_CHECKER_LEARN_EN
        w_term = (r_phase == 2'd0) ? (in_done || w_oob0) : (w_end || in_done);
        w_derr = (r_phase == 2'd0) ? (in_done || w_oob0) : (w_end ^ in_done);
`else
        w_term = w_end || in_done;
        w_derr = w_end ^ in_done;
`endif
    end

    // next-state selection; dropping enable always returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (!enable)
            w_state_nxt = S_IDLE;
        else if (r_state == S_IDLE)
            w_state_nxt = w_start_oob ? S_DONE : S_CHECK;
        else if (r_state == S_CHECK && w_sample && w_term)
            w_state_nxt = S_DONE;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // configuration latch at arm, per-sample scoring and verdict on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step            <= '0;
            r_min             <= '0;
            r_max             <= '0;
            r_exp             <= '0;
            mismatch          <= 1'b0;
            mismatch_expected <= '0;
            match_count       <= '0;
            error_count       <= '0;
            done_error        <= 1'b0;
            pass              <= 1'b0;
`ifdef SEQ_CHECKER_LEARN_EN
            r_phase           <= 2'd0;
`endif
        end else begin
            mismatch <= 1'b0;
            if (enable && r_state == S_IDLE) begin
`ifdef SEQ_CHECKER_LEARN_EN
                r_step  <= '0;
                r_exp   <= '0;
                r_phase <= 2'd0;
`else
                r_step  <= step;
                r_exp   <= start_value;
`endif
                r_min       <= range_min;
                r_max       <= range_max;
                match_count <= '0;
                error_count <= '0;
                done_error  <= w_start_oob;
                pass        <= 1'b0;
            end else if (w_sample) begin
                if (w_match)
                    match_count <= (&match_count) ? match_count : match_count + 1'b1;
                else begin
                    error_count       <= (&error_count) ? error_count : error_count + 1'b1;
                    mismatch          <= 1'b1;
                    mismatch_expected <= r_exp;
                end
                r_exp <= w_next[DATA_W-1:0];
`ifdef SEQ_CHECKER_LEARN_EN
                r_step  <= w_step_cur;
                r_phase <= (r_phase == 2'd2) ? r_phase : r_phase + 2'd1;
`endif
                if (w_term) begin
                    done_error <= done_error || w_derr;
                    pass       <= (error_count == '0) && w_match && !(done_error || w_derr);
                end
            end
        end
    end

    assign active   = (r_state == S_CHECK);
    assign complete = (r_state == S_DONE);
endmodule

// File: tb/tb_sequence_checker.sv
// tb_sequence_checker: directed self-checking bench for sequence_checker (default build)
module tb_sequence_checker;
    localparam int DW = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic signed [DW-1:0] start_value = '0, step = '0, range_min = '0, range_max = '0, in_value = '0;
    logic in_valid = 1'b0, in_done = 1'b0;
    logic active, mismatch, done_error, complete, pass;
    logic signed [DW-1:0] mismatch_expected;
    logic [CW-1:0] match_count, error_count;
    int total = 0;
    int bad = 0;

    sequence_checker #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .start_value(start_value), .step(step), .range_min(range_min), .range_max(range_max),
        .in_valid(in_valid), .in_value(in_value), .in_done(in_done),
        .active(active), .mismatch(mismatch), .mismatch_expected(mismatch_expected),
        .match_count(match_count), .error_count(error_count),
        .done_error(done_error), .complete(complete), .pass(pass)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // arming cycle carries a bogus sample that must be ignored; config is scrambled afterwards
    task automatic arm(input logic signed [DW-1:0] s, st, mn, mx);
        start_value = s; step = st; range_min = mn; range_max = mx;
        enable = 1'b1; in_valid = 1'b1; in_value = 999; in_done = 1'b1;
        tick();
        in_valid = 1'b0; in_done = 1'b0;
        start_value = -1; step = 77; range_min = 100; range_max = -100;
    endtask

    task automatic send(input logic signed [DW-1:0] v, input logic d);
        in_valid = 1'b1; in_value = v; in_done = d;
        tick();
        in_valid = 1'b0; in_done = 1'b0;
    endtask

    task automatic disarm();
        enable = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        total++; if ({active, mismatch, mismatch_expected, match_count, error_count, done_error, complete, pass} !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", {active, mismatch, mismatch_expected, match_count, error_count, done_error, complete, pass}); end
        rst_n = 1'b1;
        tick();
        total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_idle active got=%b exp=0", active); end
    endtask

    task automatic test_ascending();
        arm(10, 2, 5, 20);
        total++; if (active !== 1'b1) begin bad++; $display("FAIL asc_active got=%b exp=1", active); end
        total++; if (match_count !== 4'd0 || error_count !== 4'd0) begin bad++; $display("FAIL asc_arm_counts got=%0d/%0d exp=0/0", match_count, error_count); end
        send(10, 0); send(12, 0);
        tick();
        total++; if (match_count !== 4'd2) begin bad++; $display("FAIL asc_gap_hold got=%0d exp=2", match_count); end
        send(14, 0); send(16, 0); send(18, 0);
        total++; if (complete !== 1'b0 || active !== 1'b1) begin bad++; $display("FAIL asc_not_done got=%b%b exp=01", complete, active); end
        send(20, 1);
        total++; if (match_count !== 4'd6) begin bad++; $display("FAIL asc_match got=%0d exp=6", match_count); end
        total++; if (error_count !== 4'd0) begin bad++; $display("FAIL asc_err got=%0d exp=0", error_count); end
        total++; if (complete !== 1'b1 || active !== 1'b0) begin bad++; $display("FAIL asc_complete got=%b%b exp=10", complete, active); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL asc_pass got=%b exp=1", pass); end
        total++; if (done_error !== 1'b0) begin bad++; $display("FAIL asc_done_error got=%b exp=0", done_error); end
        disarm();
    endtask

    task automatic test_single_error();
        arm(10, 2, 5, 20);
        send(10, 0); send(12, 0); send(15, 0);
        total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b exp=1", mismatch); end
        total++; if (mismatch_expected !== 32'sd14) begin bad++; $display("FAIL err_expected got=%0d exp=14", mismatch_expected); end
        total++; if (error_count !== 4'd1) begin bad++; $display("FAIL err_count got=%0d exp=1", error_count); end
        send(16, 0);
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL err_pulse_clear got=%b exp=0", mismatch); end
        send(18, 0); send(20, 1);
        total++; if (match_count !== 4'd5 || error_count !== 4'd1) begin bad++; $display("FAIL err_final_counts got=%0d/%0d exp=5/1", match_count, error_count); end
        total++; if (complete !== 1'b1 || pass !== 1'b0 || done_error !== 1'b0) begin bad++; $display("FAIL err_verdict got=c%b p%b d%b exp=c1 p0 d0", complete, pass, done_error); end
        disarm();
    endtask

    task automatic test_descending();
        arm(10, -3, 0, 20);
        send(10, 0); send(7, 0); send(4, 0); send(1, 1);
        total++; if (match_count !== 4'd4) begin bad++; $display("FAIL desc_match got=%0d exp=4", match_count); end
        total++; if (complete !== 1'b1 || pass !== 1'b1 || done_error !== 1'b0) begin bad++; $display("FAIL desc_verdict got=c%b p%b d%b exp=c1 p1 d0", complete, pass, done_error); end
        disarm();
    endtask

    task automatic test_done_flag();
        arm(10, 2, 5, 20);
        send(10, 0); send(12, 0); send(14, 0); send(16, 1);
        total++; if (complete !== 1'b1 || done_error !== 1'b1 || pass !== 1'b0) begin bad++; $display("FAIL early_done got=c%b d%b p%b exp=c1 d1 p0", complete, done_error, pass); end
        total++; if (match_count !== 4'd4) begin bad++; $display("FAIL early_match got=%0d exp=4", match_count); end
        disarm();
        arm(10, 2, 5, 20);
        total++; if (done_error !== 1'b0) begin bad++; $display("FAIL rearm_clear_derr got=%b exp=0", done_error); end
        send(10, 0); send(12, 0); send(14, 0); send(16, 0); send(18, 0); send(20, 0);
        total++; if (complete !== 1'b1 || done_error !== 1'b1 || pass !== 1'b0) begin bad++; $display("FAIL late_done got=c%b d%b p%b exp=c1 d1 p0", complete, done_error, pass); end
        send(22, 1);
        total++; if (match_count !== 4'd6 || complete !== 1'b1) begin bad++; $display("FAIL done_ignores got=%0d c%b exp=6 c1", match_count, complete); end
        disarm();
    endtask

    task automatic test_overflow();
        arm(32'sh7FFFFFF0, 32'sh10, 32'sh80000000, 32'sh7FFFFFFF);
        send(32'sh7FFFFFF0, 1);
        total++; if (complete !== 1'b1 || pass !== 1'b1 || done_error !== 1'b0) begin bad++; $display("FAIL ovf_verdict got=c%b p%b d%b exp=c1 p1 d0", complete, pass, done_error); end
        total++; if (match_count !== 4'd1) begin bad++; $display("FAIL ovf_match got=%0d exp=1", match_count); end
        disarm();
    endtask

    task automatic test_start_oob();
        arm(30, 2, 5, 20);
        total++; if (complete !== 1'b1 || done_error !== 1'b1 || pass !== 1'b0 || active !== 1'b0) begin bad++; $display("FAIL oob_start got=c%b d%b p%b a%b exp=c1 d1 p0 a0", complete, done_error, pass, active); end
        disarm();
    endtask

    task automatic test_step_zero_saturate();
        arm(5, 0, 0, 10);
        for (int i = 0; i < 17; i++) send(5, 0);
        total++; if (active !== 1'b1 || match_count !== 4'hF) begin bad++; $display("FAIL zero_step_sat got=a%b m%0d exp=a1 m15", active, match_count); end
        send(5, 1);
        total++; if (complete !== 1'b1 || done_error !== 1'b1 || match_count !== 4'hF) begin bad++; $display("FAIL zero_step_done got=c%b d%b m%0d exp=c1 d1 m15", complete, done_error, match_count); end
        disarm();
    endtask

    task automatic test_abort();
        arm(10, 2, 5, 20);
        send(10, 0); send(12, 0);
        disarm();
        total++; if (active !== 1'b0 || complete !== 1'b0 || match_count !== 4'd2) begin bad++; $display("FAIL abort_hold got=a%b c%b m%0d exp=a0 c0 m2", active, complete, match_count); end
        arm(10, 2, 5, 20);
        total++; if (active !== 1'b1 || match_count !== 4'd0) begin bad++; $display("FAIL rearm_clear got=a%b m%0d exp=a1 m0", active, match_count); end
        send(10, 0); send(99, 0); send(14, 0);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({active, mismatch, mismatch_expected, match_count, error_count, done_error, complete, pass} !== '0) begin bad++; $display("FAIL async_reset got=%h exp=0", {active, mismatch, mismatch_expected, match_count, error_count, done_error, complete, pass}); end
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_single_error();
        test_descending();
        test_done_flag();
        test_overflow();
        test_start_oob();
        test_step_zero_saturate();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
- Receive-side counterpart of sequence_generator: consumes the (value, done) stream a generator produces and checks it against the same configuration (start, step, range).
- Reports per-sample mismatches, match/error counts, end-of-sequence consistency, and a final pass/fail verdict.
- Sits in the simple_tb environment as a self-checking monitor, and in-system as a built-in self-test of the generator output path.

Parameters:
- DATA_W, 32, signed width of values, step and range bounds.
- CNT_W, 16, width of the match/error counters (saturating).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  arm/hold; 0 returns the block to IDLE
- start_value  input  DATA_W  expected first value (signed)
- step  input  DATA_W  expected increment (signed, may be negative or zero)
- range_min  input  DATA_W  inclusive lower bound (signed)
- range_max  input  DATA_W  inclusive upper bound (signed)
- in_valid  input  1  a sample is present this cycle
- in_value  input  DATA_W  sample value (signed)
- in_done  input  1  source marks this sample as the last; qualified by in_valid
- active  output  1  state is CHECK
- mismatch  output  1  one-cycle pulse, the previous sample was wrong
- mismatch_expected  output  DATA_W  expected value of the most recent mismatch
- match_count  output  CNT_W  matching samples since arm
- error_count  output  CNT_W  mismatching samples since arm
- done_error  output  1  sticky; in_done and the range end disagreed, or start_value was out of range
- complete  output  1  state is DONE
- pass  output  1  valid only when complete=1

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; counters 0; internal expected register 0.
- States: IDLE, CHECK, DONE.
- IDLE -> CHECK when enable=1:
  - latch start_value, step, range_min, range_max;
  - set expected=start_value;
  - clear counters, done_error and pass.
  - Exception: if the latched start_value is outside [range_min, range_max], go to DONE instead, with done_error=1 and pass=0.
- Config inputs are ignored outside the arming cycle.
- CHECK, cycle with in_valid=1:
  - compare in_value to expected;
  - on a match, match_count++;
  - on a mismatch, error_count++ and next cycle mismatch=1 with mismatch_expected=expected;
  - always advance expected <= expected + step, so the checker stays aligned by position.
- End detection: end_reached = (expected + step) lies outside [range_min, range_max], evaluated at DATA_W+1 bits signed so overflow never wraps.
- Sample with end_reached=1:
  - next state DONE;
  - if in_done=0, done_error=1.
- Sample with in_done=1 and end_reached=0: done_error=1, next state DONE.
- On entry to DONE: pass=1 iff error_count==0 (including the final sample), done_error==0, and the final sample matched.
- Latency: every output is registered. The response to a sample at cycle N appears at cycle N+1.
- in_valid=0 in CHECK: no change.
- step==0: end_reached is never set; the sequence runs indefinitely until enable=0. An in_done in this case raises done_error.
- DONE: outputs held and samples ignored until enable=0. DONE -> IDLE when enable=0.
- enable=0 in any state: IDLE next cycle. Counters, flags and pass hold their values until the next arm.
- Counters saturate at all-ones and never wrap.
- A sample arriving on the arming cycle is ignored; checking starts the cycle after the IDLE -> CHECK transition.
- rst_n asserted mid-sequence: immediate return to reset values. There is no partial verdict.

Optional Feature:
- Macro: SEQ_CHECKER_LEARN_EN.
- With the macro defined:
  - start_value and step ports are ignored;
  - the first valid sample in CHECK is taken as start and counted as a match;
  - the second valid sample sets step = sample2 - sample1 (DATA_W-bit) and is counted as a match;
  - checking then proceeds normally from the third sample;
  - range and in_done checks apply from the first sample onward.
- Without the macro: start_value and step come only from the ports, latched at arm.

Test Plan:
- Normal ascending sequence. start=10, step=2, min=5, max=20; feed 10,12,14,16,18,20 with in_done on 20.
  -> match_count=6, error_count=0, complete=1, pass=1, done_error=0.
- Single wrong sample. Same config; third sample 15 instead of 14.
  -> mismatch pulse, mismatch_expected=14, error_count=1, later samples still match, pass=0.
- Descending sequence. start=10, step=-3, min=0, max=20; feed 10,7,4,1 with in_done on 1.
  -> match_count=4, pass=1.
- Done-flag disagreement.
  - Early: ascending config, in_done on 16 -> done_error=1, complete=1, pass=0.
  - Late: ascending config, in_done missing on 20 -> done_error=1.
- Overflow boundary. start=32'h7FFFFFF0, step=32'h10, max=32'h7FFFFFFF; one sample 32'h7FFFFFF0 with in_done=1.
  -> end detected without wrap, pass=1.
- Reset and abort.
  - rst_n low after 3 samples -> all outputs 0 at once.
  - enable=0 mid-sequence -> IDLE, counts held; re-arm clears them.
